// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: round-robin scheduler sharing one multi-cycle fpadd adder
// among NREQ requesters. The arbiter forwards operands and results untouched.
// Optional WAIT timeout is compiled in when FPADD_ARB_TIMEOUT_EN is defined;
// without it the arbiter waits for the adder indefinitely and rsp_err is 0.

module fpadd_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 511
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_sum,
  output logic               rsp_err,
  output logic               fpu_start,
  output logic [31:0]        fpu_a,
  output logic [31:0]        fpu_b,
  input  logic [31:0]        fpu_sum,
  input  logic               fpu_done,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("fpadd_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  gnt_idx;
  logic [PW-1:0]  sel_idx;
  logic [PW:0]    scan_idx;
  logic           sel_found;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic           wait_first;
  logic           timeout_hit;

`ifdef FPADD_ARB_TIMEOUT_EN
  localparam int          CW   = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
  assign rsp_err     = err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // Find the first pending requester at or after ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NREQ)) begin
        scan_idx = scan_idx - (PW+1)'(NREQ);
      end
      if (!sel_found && req_valid[scan_idx[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx[PW-1:0];
      end
    end
  end

  // Pick the operand slices of the selected requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == PW'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  // Accept strobe is combinational so the requester sees it in the grant cycle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state == IDLE) && !reset && sel_found && (sel_idx == PW'(i));
    end
  end

  // Main control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      fpu_start  <= 1'b0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      rsp_valid  <= '0;
      rsp_sum    <= '0;
      busy       <= 1'b0;
      wait_first <= 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      fpu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt_idx   <= sel_idx;
            fpu_a     <= sel_a;
            fpu_b     <= sel_b;
            fpu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_first <= 1'b1;
`ifdef FPADD_ARB_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
          state      <= WAIT;
        end
        WAIT: begin
          wait_first <= 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
          wait_cnt   <= wait_cnt + CW'(1);
`endif
          if (!wait_first && fpu_done) begin
            rsp_sum   <= fpu_sum;
            rsp_valid <= NREQ'(1) << gnt_idx;
            state     <= RESP;
          end else if (timeout_hit) begin
`ifdef FPADD_ARB_TIMEOUT_EN
            rsp_sum   <= QNAN;
            err_q     <= 1'b1;
`endif
            rsp_valid <= NREQ'(1) << gnt_idx;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[gnt_idx]) begin
            rsp_valid <= '0;
`ifdef FPADD_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            ptr       <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb_fpadd_arbiter: directed and randomized bench for fpadd_arbiter with a
// behavioural adder fixture and a transaction-level reference model.
// Timeout scenarios follow FPADD_ARB_TIMEOUT_EN the same way as the design.

module tb_fpadd_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [31:0]        rsp_sum;
  logic               rsp_err;
  logic               fpu_start;
  logic [31:0]        fpu_a;
  logic [31:0]        fpu_b;
  logic [31:0]        fpu_sum = '0;
  logic               fpu_done = 1'b0;
  logic               busy;

  fpadd_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_sum(fpu_sum), .fpu_done(fpu_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Stand-in adder result: any fixed function works since the arbiter only
  // forwards it; the directed 1.0 + 2.0 case returns the true IEEE sum.
  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]};
  endfunction

  // Adder fixture: latency counted from the start pulse, optional stale done.
  int          lat        = 3;
  bit          rand_lat   = 1'b0;
  bit          hold_done  = 1'b0;
  bit          never_done = 1'b0;
  bit          fx_busy    = 1'b0;
  int          fx_age     = 0;
  logic [31:0] fx_a, fx_b;

  always @(posedge clk) begin
    #3;
    if (fpu_start) begin
      fx_busy = 1'b1;
      fx_age  = 0;
      fx_a    = fpu_a;
      fx_b    = fpu_b;
      if (rand_lat) lat = $urandom_range(2, 9);
      if (!hold_done) fpu_done = 1'b0;
    end else if (fx_busy) begin
      fx_age++;
      if (fx_age == lat && !never_done) begin
        fpu_done = 1'b1;
        fpu_sum  = model_sum(fx_a, fx_b);
        fx_busy  = 1'b0;
      end else if (!(hold_done && fx_age <= 1)) begin
        fpu_done = 1'b0;
      end
    end else if (!hold_done) begin
      fpu_done = 1'b0;
    end
  end

  // Reference model: one outstanding transaction described by its accept
  // cycle and the cycle its result became known.
  bit             m_busy = 1'b0;
  int             m_acc  = 0;
  int             m_done = -1;
  int             m_g    = 0;
  int             m_ptr  = 0;
  bit             m_err  = 1'b0;
  logic [31:0]    m_rsp_sum = '0;
  logic [31:0]    m_fa = '0;
  logic [31:0]    m_fb = '0;
  logic [NREQ-1:0] exp_ready, exp_rv;
  bit             in_rsp;
  int             g_new, idx;

  logic [NREQ-1:0] grant_q[$];
  int              start_count  = 0;
  logic [NREQ-1:0] rsp_seen     = '0;
  logic [31:0]     last_rsp_sum = '0;
  logic            last_err     = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_ptr = 0; m_done = -1; m_acc = 0; m_g = 0;
      m_err = 1'b0; m_rsp_sum = '0; m_fa = '0; m_fb = '0;
    end else begin
      if (req_ready != '0) grant_q.push_back(req_ready);
      if (fpu_start) start_count++;
      if (rsp_valid != '0) begin
        rsp_seen     = rsp_seen | rsp_valid;
        last_rsp_sum = rsp_sum;
        last_err     = rsp_err;
      end
      in_rsp = m_busy && (m_done >= 0) && (cyc > m_done);
      g_new  = -1;
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (g_new < 0 && req_valid[idx]) g_new = idx;
        end
      end
      exp_ready = '0;
      if (g_new >= 0) exp_ready[g_new] = 1'b1;
      exp_rv = in_rsp ? (NREQ'(1) << m_g) : '0;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      checkOutput("fpu_start", 32'(fpu_start), 32'(m_busy && cyc == m_acc + 1));
      checkOutput("busy",      32'(busy),      32'(m_busy && cyc > m_acc));
      checkOutput("rsp_err",   32'(rsp_err),   32'(in_rsp && m_err));
      checkOutput("rsp_sum",   rsp_sum,        m_rsp_sum);
      checkOutput("fpu_a",     fpu_a,          m_fa);
      checkOutput("fpu_b",     fpu_b,          m_fb);
      if (!m_busy) begin
        if (g_new >= 0) begin
          m_busy = 1'b1; m_acc = cyc; m_g = g_new; m_done = -1; m_err = 1'b0;
          m_fa = req_a[32*g_new +: 32];
          m_fb = req_b[32*g_new +: 32];
        end
      end else if (m_done < 0) begin
        if (cyc >= m_acc + 3 && fpu_done) begin
          m_done = cyc; m_rsp_sum = model_sum(m_fa, m_fb); m_err = 1'b0;
        end
`ifdef FPADD_ARB_TIMEOUT_EN
        else if (cyc == m_acc + 1 + TMO) begin
          m_done = cyc; m_rsp_sum = 32'h7FC00000; m_err = 1'b1;
        end
`endif
      end else if (cyc > m_done && rsp_ready[m_g]) begin
        m_busy = 1'b0; m_ptr = (m_g + 1) % NREQ; m_err = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] ready, input int cycles);
    req_valid = valid;
    rsp_ready = ready;
    tick(cycles);
  endtask

  task automatic setOperand(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic applyReset(input logic [NREQ-1:0] valid);
    reset     = 1'b1;
    req_valid = valid;
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_fpu_start", 32'(fpu_start), 32'd0);
    checkOutput("rst_rsp_sum",   rsp_sum,        32'd0);
    checkOutput("rst_rsp_err",   32'(rsp_err),   32'd0);
    checkOutput("rst_fpu_a",     fpu_a,          32'd0);
    checkOutput("rst_fpu_b",     fpu_b,          32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitRspValid(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) break;
    end
    checkOutput("rsp_wait", 32'(rsp_valid != '0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [NREQ-1:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    tick(1);
    applyReset('0);

    // Single requester, 1.0 + 2.0.
    lat = 3; start_count = 0; rsp_seen = '0;
    setOperand(0, 32'h3F800000, 32'h40000000);
    applyStimulus(4'b0001, 4'b1111, 1);
    applyStimulus(4'b0000, 4'b1111, 12);
    checkOutput("t1_starts", 32'(start_count), 32'd1);
    checkOutput("t1_rsp_idx", 32'(rsp_seen), 32'h1);
    checkOutput("t1_sum", last_rsp_sum, 32'h40400000);

    // All requesters pending from reset: grants rotate 0,1,2,3,0.
    lat = 2;
    for (int i = 0; i < NREQ; i++) setOperand(i, $urandom, $urandom);
    grant_q.delete();
    rsp_ready = 4'b1111;
    applyReset(4'b1111);
    for (int c = 0; c < 200 && grant_q.size() < 5; c++) tick(1);
    checkOutput("rr_count", 32'(grant_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_q.size()) checkOutput("rr_order", 32'(grant_q[i]), 32'(exp_order[i]));
    end
    applyStimulus(4'b0000, 4'b1111, 10);

    // Response held back for 10 cycles while others keep requesting.
    lat = 4;
    applyStimulus(4'b0010, 4'b0000, 1);
    req_valid = 4'b1111;
    waitRspValid(40);
    tick(10);
    checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'h2);
    applyStimulus(4'b0000, 4'b0010, 1);
    applyStimulus(4'b0000, 4'b1111, 10);

    // Reset in WAIT: the in-flight result never comes back.
    lat = 10;
    applyStimulus(4'b0001, 4'b1111, 1);
    applyStimulus(4'b0000, 4'b1111, 3);
    applyReset('0);
    rsp_seen = '0;
    applyStimulus(4'b0000, 4'b1111, 15);
    checkOutput("rst_no_rsp", 32'(rsp_seen), 32'd0);

    // Stale done from the previous op must not be taken as the new result.
    lat = 6; hold_done = 1'b1;
    setOperand(2, 32'h11223344, 32'h55667788);
    applyStimulus(4'b0100, 4'b1111, 1);
    applyStimulus(4'b0000, 4'b1111, 15);
    setOperand(3, 32'hA5A50F0F, 32'h12345678);
    applyStimulus(4'b1000, 4'b1111, 1);
    applyStimulus(4'b0000, 4'b1111, 15);
    checkOutput("stale_sum", last_rsp_sum, model_sum(32'hA5A50F0F, 32'h12345678));
    hold_done = 1'b0;
    applyStimulus(4'b0000, 4'b1111, 2);

    // Adder that never completes.
    never_done = 1'b1; rsp_seen = '0;
    applyStimulus(4'b0001, 4'b1111, 1);
`ifdef FPADD_ARB_TIMEOUT_EN
    applyStimulus(4'b0000, 4'b1111, 25);
    checkOutput("tmo_seen", 32'(rsp_seen), 32'h1);
    checkOutput("tmo_sum", last_rsp_sum, 32'h7FC00000);
    checkOutput("tmo_err", 32'(last_err), 32'd1);
    never_done = 1'b0;
`else
    applyStimulus(4'b0000, 4'b1111, 60);
    checkOutput("stuck_busy", 32'(busy), 32'd1);
    checkOutput("stuck_no_rsp", 32'(rsp_seen), 32'd0);
    never_done = 1'b0;
    applyReset('0);
`endif

    // Randomized traffic.
    rand_lat = 1'b1;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) setOperand(i, $urandom, $urandom);
      applyStimulus(NREQ'($urandom), NREQ'($urandom), 1);
    end
    applyStimulus(4'b0000, 4'b1111, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
